// File: rtl/scb_issue_pip0.sv
// scb_issue_pip0: one-entry issue stage in front of a scoreboard cell array.
// Holds one decoded instruction and checks it for RAW, WAW and writeback-slot
// hazards. When it is clear and a cell is free, the instruction is issued to
// the lowest free cell identifier. Flush and reset discard the held entry.
// Optional feature macro: SCB_ISSUE_STALL_CNT_EN adds the saturating
// consecutive-stall counter. Without it, stall_cnt is tied to zero.
module scb_issue_pip0 #(
  parameter int N_cell  = 8,
  parameter int W_ident = 4,
  parameter int W_pip   = 2,
  parameter int W_PA_rx = 5,
  parameter int W_state = 7,
  parameter int V_FUT0  = 1,
  parameter int V_FUT1  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_pip-1:0]           in_pip,
  input  logic [W_PA_rx-1:0]         in_rd,
  input  logic [W_PA_rx-1:0]         in_rs1,
  input  logic [W_PA_rx-1:0]         in_rs2,
  input  logic                       in_fut,
  input  logic [(1<<W_PA_rx)-1:0]    busy_rd,
  input  logic [N_cell*W_ident-1:0]  candit_insert_all,
  input  logic [N_cell-1:0]          hz_wbs_0_all,
  input  logic [N_cell-1:0]          hz_wbs_1_all,
  input  logic                       CFI_PC_clear,
  output logic [W_ident-1:0]         addr_insert,
  output logic [W_pip-1:0]           o_pip,
  output logic [W_PA_rx-1:0]         o_rd_a,
  output logic [W_state-1:0]         o_state,
  output logic [7:0]                 stall_cnt
);

  typedef enum logic {ST_EMPTY, ST_HELD} state_t;

  state_t               r_state, w_state_nxt;
  logic [W_pip-1:0]     r_pip, r_last_pip;
  logic [W_PA_rx-1:0]   r_rd, r_rs1, r_rs2, r_last_rd;
  logic                 r_fut;
  logic [W_state-1:0]   r_last_state;

  logic [W_ident-1:0]   w_min;
  logic                 w_raw, w_waw, w_struct, w_issue, w_load;
  logic [W_state-1:0]   w_lat;

  // Find the lowest free cell identifier. All-ones from every cell means the array is full.
  always_comb begin
    w_min = '1;
    for (int unsigned i = 0; i < N_cell; i++) begin
      if (candit_insert_all[i*W_ident +: W_ident] < w_min)
        w_min = candit_insert_all[i*W_ident +: W_ident];
    end
  end

  // Check hazards on the held entry, then derive the issue, accept and next-state decisions.
  always_comb begin
    w_raw    = ((r_rs1 != '0) && busy_rd[r_rs1]) || ((r_rs2 != '0) && busy_rd[r_rs2]);
    w_waw    = (r_rd != '0) && busy_rd[r_rd];
    w_struct = r_fut ? (|hz_wbs_1_all) : (|hz_wbs_0_all);
    w_issue  = (r_state == ST_HELD) && !CFI_PC_clear && !w_raw && !w_waw &&
               !w_struct && (w_min != '1);
    in_ready = !CFI_PC_clear && ((r_state == ST_EMPTY) || w_issue);
    w_load   = in_ready && in_valid;
    w_state_nxt = r_state;
    if (CFI_PC_clear)   w_state_nxt = ST_EMPTY;
    else if (w_load)    w_state_nxt = ST_HELD;
    else if (w_issue)   w_state_nxt = ST_EMPTY;
  end

  // Drive the cell outputs. The data outputs keep the last issued values between issues.
  always_comb begin
    w_lat       = r_fut ? W_state'(V_FUT1) : W_state'(V_FUT0);
    addr_insert = w_issue ? w_min : '1;
    o_pip       = w_issue ? r_pip : r_last_pip;
    o_rd_a      = w_issue ? r_rd  : r_last_rd;
    o_state     = w_issue ? w_lat : r_last_state;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Holding register: loads whenever a new instruction is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pip <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_fut <= 1'b0;
    end else if (w_load) begin
      r_pip <= in_pip; r_rd <= in_rd; r_rs1 <= in_rs1; r_rs2 <= in_rs2; r_fut <= in_fut;
    end
  end

  // Record the last issued values so the cell outputs stay stable between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_pip <= '0; r_last_rd <= '0; r_last_state <= '0;
    end else if (w_issue) begin
      r_last_pip <= r_pip; r_last_rd <= r_rd; r_last_state <= w_lat;
    end
  end

`ifdef SCB_ISSUE_STALL_CNT_EN
  logic [7:0] r_stall;

  // Count consecutive held cycles without issue. Saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if ((r_state == ST_HELD) && !w_issue && !CFI_PC_clear)
      r_stall <= (r_stall == 8'hFF) ? r_stall : r_stall + 8'd1;
    else
      r_stall <= '0;
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_scb_issue_pip0.sv
// Bench for scb_issue_pip0. It runs directed vector rows, then a reset during
// HELD, then random cycles checked against a queue-based reference model.
module tb_scb_issue_pip0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_fut, CFI_PC_clear;
  logic [1:0]  in_pip, o_pip;
  logic [4:0]  in_rd, in_rs1, in_rs2, o_rd_a;
  logic [31:0] busy_rd, candit_insert_all;
  logic [7:0]  hz_wbs_0_all, hz_wbs_1_all, stall_cnt;
  logic [3:0]  addr_insert;
  logic [6:0]  o_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scb_issue_pip0 #(
    .N_cell(8), .W_ident(4), .W_pip(2), .W_PA_rx(5), .W_state(7), .V_FUT0(1), .V_FUT1(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pip(in_pip), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fut(in_fut),
    .busy_rd(busy_rd), .candit_insert_all(candit_insert_all),
    .hz_wbs_0_all(hz_wbs_0_all), .hz_wbs_1_all(hz_wbs_1_all), .CFI_PC_clear(CFI_PC_clear),
    .addr_insert(addr_insert), .o_pip(o_pip), .o_rd_a(o_rd_a), .o_state(o_state),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [1:0] pip; logic [4:0] rd, rs1, rs2; logic fut;
    logic [31:0] busy, cand; logic [7:0] hz0, hz1; logic clr;
    logic [3:0] ea; logic er; logic [1:0] ep; logic [4:0] ed; logic [6:0] es; logic [7:0] ec;
  } vec_t;

  typedef struct { logic [1:0] pip; logic [4:0] rd, rs1, rs2; logic fut; } hold_t;

  localparam logic [31:0] C1    = 32'h765432FF;
  localparam logic [31:0] CFULL = 32'hFFFFFFFF;
  localparam logic [31:0] C6    = 32'hF6FFFFFF;
  localparam logic [31:0] CALL  = 32'h76543210;

  function automatic vec_t mk(logic v, logic [1:0] pip, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic fut, logic [31:0] busy, logic [31:0] cand,
                              logic [7:0] hz0, logic [7:0] hz1, logic clr, logic [3:0] ea,
                              logic er, logic [1:0] ep, logic [4:0] ed, logic [6:0] es,
                              logic [7:0] ec);
    vec_t t;
    t.v = v; t.pip = pip; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.fut = fut;
    t.busy = busy; t.cand = cand; t.hz0 = hz0; t.hz1 = hz1; t.clr = clr;
    t.ea = ea; t.er = er; t.ep = ep; t.ed = ed; t.es = es; t.ec = ec;
    return t;
  endfunction

  // Expected stall count: the counter exists only in the feature build.
  function automatic logic [7:0] stexp(logic [7:0] v);
`ifdef SCB_ISSUE_STALL_CNT_EN
    return v;
`else
    return 8'd0 & v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic er,
                         input logic [1:0] ep, input logic [4:0] ed, input logic [6:0] es,
                         input logic [7:0] ec);
    chk({tag, ".addr"},  32'(addr_insert), 32'(ea));
    chk({tag, ".ready"}, 32'(in_ready),    32'(er));
    chk({tag, ".pip"},   32'(o_pip),       32'(ep));
    chk({tag, ".rd"},    32'(o_rd_a),      32'(ed));
    chk({tag, ".state"}, 32'(o_state),     32'(es));
    chk({tag, ".stall"}, 32'(stall_cnt),   32'(stexp(ec)));
  endtask

  task automatic drive(input vec_t t);
    in_valid = t.v; in_pip = t.pip; in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2;
    in_fut = t.fut; busy_rd = t.busy; candit_insert_all = t.cand;
    hz_wbs_0_all = t.hz0; hz_wbs_1_all = t.hz1; CFI_PC_clear = t.clr;
  endtask

  // Reference model state
  hold_t      m_q[$];
  logic [1:0] m_pip;
  logic [4:0] m_rd;
  logic [6:0] m_st;
  int         m_stall;

  function automatic bit m_can_issue(hold_t h);
    bit   raw, waw, strc;
    int   ids[$];
    int   mn[$];
    raw  = (h.rs1 != 0 && busy_rd[h.rs1] == 1'b1) || (h.rs2 != 0 && busy_rd[h.rs2] == 1'b1);
    waw  = (h.rd != 0 && busy_rd[h.rd] == 1'b1);
    strc = (h.fut == 1'b0) ? (hz_wbs_0_all != 0) : (hz_wbs_1_all != 0);
    for (int i = 0; i < 8; i++) ids.push_back(int'(candit_insert_all[i*4 +: 4]));
    mn = ids.min();
    return !raw && !waw && !strc && (mn[0] != 15);
  endfunction

  function automatic logic [3:0] m_min_id();
    int ids[$];
    int mn[$];
    for (int i = 0; i < 8; i++) ids.push_back(int'(candit_insert_all[i*4 +: 4]));
    mn = ids.min();
    return 4'(mn[0]);
  endfunction

  vec_t vq[$];

  initial begin
    vec_t z;
    bit   iss, rdy;
    hold_t h;
    logic [6:0] lat;

    z = mk(0,0,0,0,0,0, 0,CALL,0,0,0, 0,0,0,0,0,0);
    drive(z);
    rst_n = 1'b0;
    #3;
    chk("rst.addr",  32'(addr_insert), 32'hF);
    chk("rst.stall", 32'(stall_cnt),   32'h0);
    chk("rst.rd",    32'(o_rd_a),      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed rows, one clock cycle each
    vq.push_back(mk(1,1,3,1,2,0, 0,C1,0,0,0,           4'hF,1, 0,0,0, 0));
    vq.push_back(mk(0,1,3,1,2,0, 0,C1,0,0,0,           4'h2,1, 1,3,1, 0));
    vq.push_back(mk(1,2,6,5,0,0, 32'h20,C1,0,0,0,      4'hF,1, 1,3,1, 0));
    vq.push_back(mk(0,2,6,5,0,0, 32'h20,C1,0,0,0,      4'hF,0, 1,3,1, 0));
    vq.push_back(mk(0,2,6,5,0,0, 32'h20,C1,0,0,0,      4'hF,0, 1,3,1, 1));
    vq.push_back(mk(0,2,6,5,0,0, 32'h20,C1,0,0,0,      4'hF,0, 1,3,1, 2));
    vq.push_back(mk(0,2,6,5,0,0, 0,C1,0,0,0,           4'h2,1, 2,6,1, 3));
    vq.push_back(mk(0,0,0,0,0,0, 0,C1,0,0,0,           4'hF,1, 2,6,1, 0));
    vq.push_back(mk(1,3,7,0,0,1, 0,C1,0,8'h04,0,       4'hF,1, 2,6,1, 0));
    vq.push_back(mk(0,3,7,0,0,1, 0,C1,0,8'h04,0,       4'hF,0, 2,6,1, 0));
    vq.push_back(mk(0,3,7,0,0,1, 0,CFULL,0,0,0,        4'hF,0, 2,6,1, 1));
    vq.push_back(mk(0,3,7,0,0,1, 0,C6,0,0,0,           4'h6,1, 3,7,4, 2));
    vq.push_back(mk(1,0,8,9,10,0, 0,CALL,0,0,0,        4'hF,1, 3,7,4, 0));
    vq.push_back(mk(1,1,9,0,0,1, 0,CALL,0,0,0,         4'h0,1, 0,8,1, 0));
    vq.push_back(mk(0,1,9,0,0,1, 0,CALL,0,0,0,         4'h0,1, 1,9,4, 0));
    vq.push_back(mk(1,2,0,0,0,0, 32'h1,CALL,0,0,0,     4'hF,1, 1,9,4, 0));
    vq.push_back(mk(0,2,0,0,0,0, 32'h1,CALL,0,0,0,     4'h0,1, 2,0,1, 0));
    vq.push_back(mk(1,1,4,4,0,0, 32'h10,CALL,0,0,0,    4'hF,1, 2,0,1, 0));
    vq.push_back(mk(0,1,4,4,0,0, 32'h10,CALL,0,0,0,    4'hF,0, 2,0,1, 0));
    vq.push_back(mk(1,1,4,4,0,0, 0,CALL,0,0,1,         4'hF,0, 2,0,1, 1));
    vq.push_back(mk(0,0,0,0,0,0, 0,CALL,0,0,0,         4'hF,1, 2,0,1, 0));
    vq.push_back(mk(0,0,0,0,0,0, 0,CALL,0,0,0,         4'hF,1, 2,0,1, 0));

    foreach (vq[i]) begin
      drive(vq[i]);
      #4;
      chk_all($sformatf("row%0d", i), vq[i].ea, vq[i].er, vq[i].ep, vq[i].ed, vq[i].es, vq[i].ec);
      @(posedge clk); #1;
    end

    // Reset asserted while an instruction is held and stalling
    drive(mk(1,3,2,1,1,1, 32'h2,CALL,0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midheld.stall", 32'(stall_cnt), 32'(stexp(8'd2)));
    #2 rst_n = 1'b0;
    #1;
    chk_all("inreset", 4'hF, 1'b1, 2'd0, 5'd0, 7'd0, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_rd = '0;
    #4;
    chk("postrst.addr",  32'(addr_insert), 32'hF);
    chk("postrst.ready", 32'(in_ready),    32'h1);
    @(posedge clk); #1;

    // Random cycles against the reference model
    m_q.delete(); m_pip = '0; m_rd = '0; m_st = '0; m_stall = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_pip = 2'($urandom); in_rd = 5'($urandom_range(0, 7));
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_fut = 1'($urandom_range(0, 1));
      busy_rd = $urandom & $urandom & $urandom;
      for (int k = 0; k < 8; k++)
        candit_insert_all[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      hz_wbs_0_all = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      hz_wbs_1_all = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      CFI_PC_clear = ($urandom_range(0, 19) == 0);
      #4;
      iss = (m_q.size() == 1) && !CFI_PC_clear && m_can_issue(m_q[0]);
      rdy = !CFI_PC_clear && ((m_q.size() == 0) || iss);
      if (iss) begin
        h = m_q[0];
        lat = h.fut ? 7'd4 : 7'd1;
        chk_all("rnd", m_min_id(), 1'b1, h.pip, h.rd, lat, 8'(m_stall));
      end else begin
        chk_all("rnd", 4'hF, rdy, m_pip, m_rd, m_st, 8'(m_stall));
      end
      if (CFI_PC_clear) begin
        m_q.delete();
        m_stall = 0;
      end else begin
        if (m_q.size() == 1 && !iss) m_stall = (m_stall == 255) ? 255 : m_stall + 1;
        else m_stall = 0;
        if (iss) begin
          h = m_q.pop_front();
          m_pip = h.pip; m_rd = h.rd; m_st = h.fut ? 7'd4 : 7'd1;
        end
        if (rdy && in_valid) begin
          h.pip = in_pip; h.rd = in_rd; h.rs1 = in_rs1; h.rs2 = in_rs2; h.fut = in_fut;
          m_q.push_back(h);
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
